// File: rtl/slurm16_cpu_register_file_if.sv
// Bus between decode/writeback and the slurm16 register file.
// master drives addresses, write data and stall; slave returns registered read data and busy.
interface slurm16_cpu_register_file_if #(
  parameter int REG_BITS  = 4,
  parameter int BITS      = 16,
  parameter int BANK_BITS = 1
);
  logic [BANK_BITS-1:0] bank_sel;
  logic [REG_BITS-1:0]  regIn;
  logic                 regIn_we;
  logic [BITS-1:0]      regIn_data;
  logic [REG_BITS-1:0]  regOutA;
  logic [REG_BITS-1:0]  regOutB;
  logic                 rd_stall;
  logic [BITS-1:0]      regOutA_data;
  logic [BITS-1:0]      regOutB_data;
  logic                 busy;

  // No valid/ready: a write is taken on every edge with regIn_we=1 while busy=0,
  // and read data is valid one edge after its address whenever busy=0.
  modport master (
    output bank_sel, regIn, regIn_we, regIn_data, regOutA, regOutB, rd_stall,
    input  regOutA_data, regOutB_data, busy
  );

  modport slave (
    input  bank_sel, regIn, regIn_we, regIn_data, regOutA, regOutB, rd_stall,
    output regOutA_data, regOutB_data, busy
  );
endinterface

// File: rtl/slurm16_cpu_register_file.sv
// Banked two-read/one-write register file with write-first bypass, read stall
// and a post-reset clear sequencer that zeroes every bank before use.
module slurm16_cpu_register_file #(
  parameter int REG_BITS  = 4,
  parameter int BITS      = 16,
  parameter int BANK_BITS = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                              CLK,
  input  logic                              RSTb,
  slurm16_cpu_register_file_if.slave        rf,
  output logic                              dbg_state_o
);
  localparam int ADDR_W = REG_BITS + BANK_BITS;
  localparam int N      = 2 ** ADDR_W;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0]   rd_a_q, rd_a_d;
  logic [BITS-1:0]   rd_b_q, rd_b_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BITS-1:0]   wr_data;

  // One copy per read port, both written identically.
  logic [BITS-1:0] mem_a [N];
  logic [BITS-1:0] mem_b [N];

  function automatic logic [BITS-1:0] read_sel(
    input logic [REG_BITS-1:0] addr,
    input logic [BITS-1:0]     stored,
    input logic                we,
    input logic [REG_BITS-1:0] waddr,
    input logic [BITS-1:0]     wdata
  );
    if (ZERO_REG != 0 && addr == '0) return '0;
    else if (we && waddr == addr)    return wdata;
    else                             return stored;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_data = '0;
    case (state_q)
      ST_CLEAR: begin
        wr_en  = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        rd_a_d = '0;
        rd_b_d = '0;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        wr_en   = rf.regIn_we;
        wr_addr = {rf.bank_sel, rf.regIn};
        wr_data = rf.regIn_data;
        if (!rf.rd_stall) begin
          rd_a_d = read_sel(rf.regOutA, mem_a[{rf.bank_sel, rf.regOutA}],
                            rf.regIn_we, rf.regIn, rf.regIn_data);
          rd_b_d = read_sel(rf.regOutB, mem_b[{rf.bank_sel, rf.regOutB}],
                            rf.regIn_we, rf.regIn, rf.regIn_data);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
    end
  end

  // Storage has no reset; the clear sequencer is what initialises it.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_a[wr_addr] <= wr_data;
      mem_b[wr_addr] <= wr_data;
    end
  end

  assign rf.regOutA_data = rd_a_q;
  assign rf.regOutB_data = rd_b_q;
  assign rf.busy         = (state_q == ST_CLEAR);
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_slurm16_cpu_register_file.sv
// Directed-vector bench for slurm16_cpu_register_file with default parameters (N=32).
module tb_slurm16_cpu_register_file;
  logic CLK = 1'b0;
  logic RSTb;
  logic dbg_state;
  int   n_vec = 0;
  int   n_err = 0;
  int   edges;

  slurm16_cpu_register_file_if rf ();

  slurm16_cpu_register_file dut (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .rf          (rf.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    rf.bank_sel   = '0;
    rf.regIn      = '0;
    rf.regIn_we   = 1'b0;
    rf.regIn_data = '0;
    rf.regOutA    = '0;
    rf.regOutB    = '0;
    rf.rd_stall   = 1'b0;
  endtask

  task automatic write_reg(input logic b, input logic [3:0] r, input logic [15:0] d);
    rf.bank_sel = b; rf.regIn = r; rf.regIn_data = d; rf.regIn_we = 1'b1;
    tick();
    rf.regIn_we = 1'b0;
  endtask

  task automatic read_reg(input logic b, input logic [3:0] ra, input logic [3:0] rb);
    rf.bank_sel = b; rf.regOutA = ra; rf.regOutB = rb;
    tick();
  endtask

  // Counts edges until busy drops; bounded so a stuck sequencer still reports.
  task automatic count_clear(input string tag);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (rf.busy && edges < 100);
    chk(tag, edges, 32);
    chk({tag, "_busy"}, rf.busy, 0);
    chk({tag, "_state"}, dbg_state, 1);
  endtask

  initial begin
    idle();
    RSTb = 1'b0;
    #12;
    chk("rst_busy", rf.busy, 1);
    chk("rst_a", rf.regOutA_data, 0);
    chk("rst_b", rf.regOutB_data, 0);
    chk("rst_state", dbg_state, 0);

    // writes during clear must be ignored, including the final clear edge
    rf.regIn_we = 1'b1; rf.regIn = 4'd5; rf.regIn_data = 16'hFFFF;
    @(negedge CLK);
    RSTb = 1'b1;
    count_clear("clear_edges");
    rf.regIn_we = 1'b0;

    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 16; r++) begin
        read_reg(b[0], r[3:0], 4'(15 - r));
        chk("init_a", rf.regOutA_data, 0);
        chk("init_b", rf.regOutB_data, 0);
      end

    write_reg(1'b0, 4'd3, 16'hBEEF);
    read_reg(1'b0, 4'd3, 4'd3);
    chk("wr_rd_a", rf.regOutA_data, 16'hBEEF);
    chk("wr_rd_b", rf.regOutB_data, 16'hBEEF);

    write_reg(1'b0, 4'd0, 16'h1234);
    read_reg(1'b0, 4'd0, 4'd3);
    chk("r0_zero", rf.regOutA_data, 0);
    chk("r0_other", rf.regOutB_data, 16'hBEEF);

    write_reg(1'b0, 4'd6, 16'h0006);
    rf.regIn_we = 1'b1; rf.regIn = 4'd7; rf.regIn_data = 16'hA5A5;
    rf.regOutA = 4'd7; rf.regOutB = 4'd6;
    tick();
    chk("byp_a", rf.regOutA_data, 16'hA5A5);
    chk("byp_b", rf.regOutB_data, 16'h0006);
    rf.regIn = 4'd0; rf.regIn_data = 16'h5A5A;
    rf.regOutA = 4'd0; rf.regOutB = 4'd7;
    tick();
    rf.regIn_we = 1'b0;
    chk("byp_r0_a", rf.regOutA_data, 0);
    chk("byp_r0_b", rf.regOutB_data, 16'hA5A5);

    write_reg(1'b0, 4'd2, 16'h1111);
    write_reg(1'b1, 4'd2, 16'h2222);
    read_reg(1'b0, 4'd2, 4'd2);
    chk("bank0_a", rf.regOutA_data, 16'h1111);
    chk("bank0_b", rf.regOutB_data, 16'h1111);
    read_reg(1'b1, 4'd2, 4'd2);
    chk("bank1_a", rf.regOutA_data, 16'h2222);
    chk("bank1_b", rf.regOutB_data, 16'h2222);
    read_reg(1'b1, 4'd3, 4'd7);
    chk("bank1_r3", rf.regOutA_data, 0);
    chk("bank1_r7", rf.regOutB_data, 0);
    read_reg(1'b0, 4'd2, 4'd2);
    chk("bank_back", rf.regOutA_data, 16'h1111);

    rf.rd_stall = 1'b1;
    rf.regIn_we = 1'b1; rf.regIn = 4'd2; rf.regIn_data = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_a", rf.regOutA_data, 16'h1111);
      chk("stall_b", rf.regOutB_data, 16'h1111);
    end
    rf.regIn_we = 1'b0; rf.rd_stall = 1'b0;
    tick();
    chk("unstall_a", rf.regOutA_data, 16'h3333);
    chk("unstall_b", rf.regOutB_data, 16'h3333);

    // reset mid-run: asynchronous effect checked before the next edge
    RSTb = 1'b0;
    #1;
    chk("mrun_busy", rf.busy, 1);
    chk("mrun_a", rf.regOutA_data, 0);
    chk("mrun_b", rf.regOutB_data, 0);
    @(negedge CLK);
    RSTb = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mclr_busy_pre", rf.busy, 1);
    RSTb = 1'b0;
    #1;
    chk("mclr_busy", rf.busy, 1);
    chk("mclr_state", dbg_state, 0);
    @(negedge CLK);
    RSTb = 1'b1;
    count_clear("reclear_edges");

    read_reg(1'b0, 4'd2, 4'd3);
    chk("post_b0r2", rf.regOutA_data, 0);
    chk("post_b0r3", rf.regOutB_data, 0);
    read_reg(1'b1, 4'd2, 4'd6);
    chk("post_b1r2", rf.regOutA_data, 0);
    chk("post_b1r6", rf.regOutB_data, 0);
    read_reg(1'b0, 4'd7, 4'd6);
    chk("post_b0r7", rf.regOutA_data, 0);
    chk("post_b0r6", rf.regOutB_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
